// File: rtl/serial_link_pkg.sv
// Shared types and helpers for the serial link credit layer.
package serial_link_pkg;

   typedef enum logic [1:0] {
      LoadNone,
      LoadData,
      LoadCredit
   } load_kind_e;

   function automatic int unsigned credit_width(input int unsigned numCredits);
      return $clog2(numCredits + 1);
   endfunction

endpackage

// File: rtl/serial_link_credit_ctrl.sv
// Credit-based flow control between the network layer and the serial data link:
// stamps owed credits onto outgoing packets and accounts credits on incoming ones.
module serial_link_credit_ctrl
   import serial_link_pkg::*;
#(
   parameter type         payload_t       = logic,
   parameter int unsigned NumCredits      = 8,
   parameter int unsigned ForceSendThresh = NumCredits - 2,
   localparam int unsigned CreditW        = credit_width(NumCredits),
   localparam int unsigned PktW           = 1 + CreditW + $bits(payload_t)
) (
   input  logic                         clk_i,
   input  logic                         rst_i,
   input  logic                         clear_i,
   input  logic [$bits(payload_t)-1:0]  tx_data_i,
   input  logic                         tx_valid_i,
   output logic                         tx_ready_o,
   output logic [PktW-1:0]              pkt_out_o,
   output logic                         pkt_out_valid_o,
   input  logic                         pkt_out_ready_i,
   input  logic [PktW-1:0]              pkt_in_i,
   input  logic                         pkt_in_valid_i,
   output logic                         pkt_in_ready_o,
   output logic [$bits(payload_t)-1:0]  rx_data_o,
   output logic                         rx_valid_o,
   input  logic                         rx_ready_i,
   output logic [CreditW-1:0]           credits_avail_o,
   output logic [CreditW-1:0]           credits_owed_o,
   output logic                         credit_err_o
);

   localparam int unsigned SumW = CreditW + 1;

   typedef logic [CreditW-1:0] credit_t;

   typedef struct packed {
      logic     data_valid;
      credit_t  credits;
      payload_t data;
   } link_pkt_t;

   if (ForceSendThresh < 1 || ForceSendThresh > NumCredits) begin : gen_thresh_check
      $error("ForceSendThresh must lie in 1..NumCredits");
   end

   link_pkt_t        pktIn;
   link_pkt_t        outPkt_q, outPkt_d;
   logic             outValid_q, outValid_d;
   credit_t          credits_q, credits_d;
   credit_t          owed_q, owed_d;
   logic             err_q, err_d;
   load_kind_e       loadKind;
   logic             load;
   logic             pktInHs;
   logic             rxHs;
   logic [SumW-1:0]  creditSum;
   logic [SumW-1:0]  owedSum;

   assign pktIn = pkt_in_i;
   assign load  = ~outValid_q | pkt_out_ready_i;

   // Data always wins over a credit-only packet; it carries the owed credits anyway.
   always_comb begin
      loadKind = LoadNone;
      if (load && tx_valid_i && (credits_q != '0)) begin
         loadKind = LoadData;
      end else if (load && (owed_q >= credit_t'(ForceSendThresh))) begin
         loadKind = LoadCredit;
      end
   end

   assign tx_ready_o      = (loadKind == LoadData);
   assign pkt_out_o       = outPkt_q;
   assign pkt_out_valid_o = outValid_q;

   assign rx_valid_o      = pkt_in_valid_i & pktIn.data_valid;
   assign rx_data_o       = pktIn.data;
   assign pkt_in_ready_o  = pktIn.data_valid ? rx_ready_i : 1'b1;
   assign pktInHs         = pkt_in_valid_i & pkt_in_ready_o;
   assign rxHs            = rx_valid_o & rx_ready_i;

   assign credits_avail_o = credits_q;
   assign credits_owed_o  = owed_q;
   assign credit_err_o    = err_q;

   always_comb begin
      outPkt_d   = outPkt_q;
      outValid_d = outValid_q;
      err_d      = err_q;

      unique case (loadKind)
         LoadData: begin
            outPkt_d.data_valid = 1'b1;
            outPkt_d.credits    = owed_q;
            outPkt_d.data       = tx_data_i;
            outValid_d          = 1'b1;
         end
         LoadCredit: begin
            outPkt_d.data_valid = 1'b0;
            outPkt_d.credits    = owed_q;
            outPkt_d.data       = '0;
            outValid_d          = 1'b1;
         end
         default: begin
            if (pkt_out_ready_i) begin
               outValid_d = 1'b0;
            end
         end
      endcase

      // Sums are one bit wider so an overflow is visible before saturation.
      creditSum = SumW'(credits_q) - SumW'(loadKind == LoadData)
                + (pktInHs ? SumW'(pktIn.credits) : '0);
      owedSum   = ((loadKind == LoadNone) ? SumW'(owed_q) : '0) + SumW'(rxHs);

      credits_d = credit_t'(creditSum);
      if (creditSum > SumW'(NumCredits)) begin
         credits_d = credit_t'(NumCredits);
         err_d     = 1'b1;
      end

      owed_d = credit_t'(owedSum);
      if (owedSum > SumW'(NumCredits)) begin
         owed_d = credit_t'(NumCredits);
         err_d  = 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i || clear_i) begin
         outPkt_q   <= '0;
         outValid_q <= 1'b0;
         credits_q  <= credit_t'(NumCredits);
         owed_q     <= '0;
         err_q      <= 1'b0;
      end else begin
         outPkt_q   <= outPkt_d;
         outValid_q <= outValid_d;
         credits_q  <= credits_d;
         owed_q     <= owed_d;
         err_q      <= err_d;
      end
   end

endmodule
